// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready handshake bundle for one pipeline stage
//
// Purpose: groups the upstream and downstream handshake, control and payload
//          signals of pipe_stage_reg.
// Signals:
//   in_valid/in_ready/in_ctrl/in_data      upstream entry and stage readiness
//   out_valid/out_ready/out_ctrl/out_data  downstream entry and consumer readiness
// Modports:
//   slave   the stage itself (consumes in_*, produces out_*)
//   master  the surrounding pipeline (produces in_*, consumes out_*)
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_ctrl,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_ctrl,
        output out_data
    );

    modport master (
        output in_valid,
        output in_ctrl,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_ctrl,
        input  out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with flush and stall
//
// Purpose: carries a control bundle and payload between pipeline stages with a
//          valid/ready handshake, synchronous flush and back-pressure stall.
//          Control bits are zeroed on flush (and on bubbles when BUBBLE_CLR=1)
//          so downstream sees no side effects from dead entries.
// Build option: define PIPE_STAGE_SKID_EN for a 2-entry skid buffer whose
//          in_ready comes from a flop; otherwise a single register whose
//          in_ready depends combinationally on out_ready.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous kill of held and presented entries
//   bus        pipe_stage_reg_if.slave (in_* upstream, out_* downstream)
//   occupancy  number of held entries (0..1, or 0..2 with skid)
module pipe_stage_reg #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 128,
    parameter bit BUBBLE_CLR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipe_stage_reg_if.slave       bus,
    output logic [1:0]            occupancy
);

    logic              out_valid_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic [DATA_W-1:0] out_data_q;
    logic              accept;
    logic              emit;

    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = out_ctrl_q;
    assign bus.out_data  = out_data_q;

    assign accept = bus.in_valid & bus.in_ready & ~flush;
    assign emit   = out_valid_q & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    // Readiness only depends on the skid flop; rst gating keeps it low in reset.
    assign bus.in_ready = rst & ~skid_valid_q;
    assign occupancy    = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_ctrl_q   <= '0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            out_ctrl_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
        end else if (accept) begin
            // accept implies the skid slot is empty
            if (!out_valid_q || emit) begin
                out_valid_q <= 1'b1;
                out_ctrl_q  <= bus.in_ctrl;
                out_data_q  <= bus.in_data;
            end else begin
                skid_valid_q <= 1'b1;
                skid_ctrl_q  <= bus.in_ctrl;
                skid_data_q  <= bus.in_data;
            end
        end else if (emit) begin
            if (skid_valid_q) begin
                out_ctrl_q   <= skid_ctrl_q;
                out_data_q   <= skid_data_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= 1'b0;
                if (BUBBLE_CLR) begin
                    out_ctrl_q <= '0;
                end
            end
        end
    end
`else
    assign bus.in_ready = rst & (~out_valid_q | bus.out_ready);
    assign occupancy    = {1'b0, out_valid_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_data_q  <= '0;
        end else if (flush) begin
            // payload is left alone; only control must be neutralised
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_ctrl_q  <= bus.in_ctrl;
            out_data_q  <= bus.in_data;
        end else if (emit) begin
            out_valid_q <= 1'b0;
            if (BUBBLE_CLR) begin
                out_ctrl_q <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int CTRL_W     = 8;
    localparam int DATA_W     = 128;
    localparam bit BUBBLE_CLR = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] occupancy;

    pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

    pipe_stage_reg #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .BUBBLE_CLR(BUBBLE_CLR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference: queue of held entries, head is what is presented downstream
    ent_t              q[$];
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ctrl = '0;
        m_data = '0;
    endtask

    // one clock: drive at negedge, compare against model, advance model at posedge
    task automatic step(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                        input logic ordy, input logic fl);
        logic mr;
        logic acc;
        logic emt;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_ctrl   = ic;
        bus.in_data   = id;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        mr = rst && ((DEPTH == 2) ? (q.size() < 2) : (q.size() == 0 || ordy));
        chk("in_ready",  DATA_W'(bus.in_ready),  DATA_W'(mr));
        chk("out_valid", DATA_W'(bus.out_valid), DATA_W'(q.size() != 0));
        chk("out_ctrl",  DATA_W'(bus.out_ctrl),  DATA_W'(m_ctrl));
        chk("out_data",  bus.out_data,           m_data);
        chk("occupancy", DATA_W'(occupancy),     DATA_W'(q.size()));
        acc = iv && mr && !fl;
        emt = (q.size() != 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_ctrl = '0;
        end else begin
            if (emt) void'(q.pop_front());
            if (acc) q.push_back('{c: ic, d: id});
            if (q.size() != 0) begin
                m_ctrl = q[0].c;
                m_data = q[0].d;
            end else if (emt && BUBBLE_CLR) begin
                m_ctrl = '0;
            end
        end
    endtask

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", DATA_W'(bus.out_valid), '0);
        chk("rst_ready", DATA_W'(bus.in_ready),  '0);
        chk("rst_occ",   DATA_W'(occupancy),     '0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // reset mid-stream takes effect without a clock edge
        step(1'b1, 8'hA5, 128'h1234, 1'b0, 1'b0);
        #2;
        chk("mid_pre_valid", DATA_W'(bus.out_valid), DATA_W'(1));
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", DATA_W'(bus.out_valid), '0);
        chk("mid_rst_ctrl",  DATA_W'(bus.out_ctrl),  '0);
        chk("mid_rst_data",  bus.out_data,           '0);
        chk("mid_rst_occ",   DATA_W'(occupancy),     '0);
        chk("mid_rst_ready", DATA_W'(bus.in_ready),  '0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // streaming 1..4 with no bubbles
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'h11, DATA_W'(i), 1'b1, 1'b0);
            #1;
            chk("strm_valid", DATA_W'(bus.out_valid), DATA_W'(1));
            chk("strm_data",  bus.out_data,           DATA_W'(i));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // stall holding 7, then release: 7 then 8
        step(1'b1, 8'h07, 128'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h08, 128'd8, 1'b0, 1'b0);
            #1;
            chk("stall_data", bus.out_data, 128'd7);
`ifdef PIPE_STAGE_SKID_EN
            chk("stall_occ",   DATA_W'(occupancy),    DATA_W'(2));
            chk("stall_ready", DATA_W'(bus.in_ready), '0);
`endif
        end
        step(1'b1, 8'h08, 128'd8, 1'b1, 1'b0);
        #1;
        chk("release_data", bus.out_data, 128'd8);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // flush with a full stage and a presented entry
        step(1'b1, 8'h3C, 128'd5, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 128'd6, 1'b0, 1'b0);
        step(1'b1, 8'h99, 128'd9, 1'b0, 1'b1);
        #1;
        chk("flush_valid", DATA_W'(bus.out_valid), '0);
        chk("flush_ctrl",  DATA_W'(bus.out_ctrl),  '0);
        chk("flush_occ",   DATA_W'(occupancy),     '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            #1;
            chk("flush_no9", DATA_W'(bus.out_valid), '0);
        end

        // bubble after a single entry
        step(1'b1, 8'hFF, 128'hBEEF, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        #1;
        chk("bubble_valid", DATA_W'(bus.out_valid), '0);
        chk("bubble_ctrl",  DATA_W'(bus.out_ctrl),  BUBBLE_CLR ? '0 : DATA_W'(8'hFF));

        // random traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0,
                 CTRL_W'($urandom),
                 {$urandom, $urandom, $urandom, 32'(i)},
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
